mdu_ctrl: RTL and testbench

- Multiply/divide sequencer for the EX stage. Owns the HI/LO registers.
- Accepts SPECIAL-class MULT/MULTU/DIV/DIVU/MTHI/MTLO operations, selected by the 6-bit funct code that the decoder passes through unchanged.
- Runs a 32-iteration radix-2 shift-add multiply or restoring divide on one shared adder. Holds the pipeline with a stall until the result is committed.
- Sits beside the ALU in EX. Its stall feeds the hazard/stall controller.

---
 rtl/mdu_ctrl_pkg.sv | 23 ++
 rtl/mdu_ctrl_if.sv | 26 ++
 rtl/mdu_iter_step.sv | 40 ++++
 rtl/mdu_ctrl.sv | 157 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer: SPECIAL funct codes and FSM
// state type.
package mdu_ctrl_pkg;

  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } mdu_state_e;

  function automatic logic is_muldiv(input logic [5:0] funct);
    return (funct >= FUNCT_MULT) && (funct <= FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage request/response bundle between the pipeline and the multiply/divide sequencer.
interface mdu_ctrl_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              flush;
  logic              start;
  logic [5:0]        funct;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              stall;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output flush, start, funct, op_a, op_b,
    input  stall, done, hi, lo
  );

  modport slave (
    input  flush, start, funct, op_a, op_b,
    output stall, done, hi, lo
  );

endinterface

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration on a single shared adder: shift-add multiply or restoring divide.
module mdu_iter_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0]   operand_i,
  input  logic                div_i,
  output logic [2*DATA_W-1:0] acc_o,
  output logic                q_bit_o
);

  logic [DATA_W:0]   add_a;
  logic [DATA_W:0]   add_b;
  logic [DATA_W+1:0] sum;

  always_comb begin
    if (div_i) begin
      // Remainder already shifted left by one, including the bit carried out of the top.
      add_a = acc_i[2*DATA_W-1:DATA_W-1];
      add_b = {1'b0, operand_i};
    end else begin
      add_a = {1'b0, acc_i[2*DATA_W-1:DATA_W]};
      add_b = acc_i[0] ? {1'b0, operand_i} : '0;
    end

    sum = {1'b0, add_a} + ({1'b0, add_b} ^ {(DATA_W+2){div_i}})
        + {{(DATA_W+1){1'b0}}, div_i};

    if (div_i) begin
      q_bit_o = ~sum[DATA_W+1];
      // Quotient bit is left as zero here; the caller merges q_bit_o into bit 0.
      acc_o   = {q_bit_o ? sum[DATA_W-1:0] : acc_i[2*DATA_W-2:DATA_W-1],
                 acc_i[DATA_W-2:0], 1'b0};
    end else begin
      q_bit_o = 1'b0;
      acc_o   = {sum[DATA_W:0], acc_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for EX: owns HI/LO, runs 32 iterations per MULT*/DIV* and stalls the
// pipeline until the result commits.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input logic       clk,
  input logic       rst_n,
  mdu_ctrl_if.slave bus
);

  mdu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d, acc_step;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic                div_q, div_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                q_bit;
  logic                stall_c, done_c;

  logic                req_div, req_signed, a_neg, b_neg;
  logic [DATA_W-1:0]   abs_a, abs_b, quot_fix, rem_fix;
  logic [2*DATA_W-1:0] prod_fix;

  mdu_iter_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .div_i     (div_q),
    .acc_o     (acc_step),
    .q_bit_o   (q_bit)
  );

  always_comb begin
    req_div    = (bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_DIVU);
    req_signed = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);
    a_neg      = req_signed & bus.op_a[DATA_W-1];
    b_neg      = req_signed & bus.op_b[DATA_W-1];
    abs_a      = a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
    abs_b      = b_neg ? (~bus.op_b + 1'b1) : bus.op_b;

    prod_fix   = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot_fix   = neg_q ? (~acc_q[DATA_W-1:0] + 1'b1) : acc_q[DATA_W-1:0];
    rem_fix    = rneg_q ? (~acc_q[2*DATA_W-1:DATA_W] + 1'b1) : acc_q[2*DATA_W-1:DATA_W];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stall_c = 1'b0;
    done_c  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.funct == FUNCT_MTHI) begin
            hi_d = bus.op_a;
          end else if (bus.funct == FUNCT_MTLO) begin
            lo_d = bus.op_a;
          end else if (is_muldiv(bus.funct)) begin
            stall_c = 1'b1;
            if (req_div && (bus.op_b == '0)) begin
              state_d = StDone;
            end else begin
              // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
              acc_d   = {{DATA_W{1'b0}}, req_div ? abs_a : abs_b};
              opnd_d  = req_div ? abs_b : abs_a;
              div_d   = req_div;
              neg_d   = a_neg ^ b_neg;
              rneg_d  = a_neg;
              cnt_d   = '0;
              state_d = StCalc;
            end
          end
        end
      end
      StCalc: begin
        stall_c = 1'b1;
        acc_d   = acc_step | {{(2*DATA_W-1){1'b0}}, q_bit};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d   = '0;
          state_d = StFix;
        end
      end
      StFix: begin
        stall_c = 1'b1;
        if (div_q) begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*DATA_W-1:DATA_W];
          lo_d = prod_fix[DATA_W-1:0];
        end
        state_d = StDone;
      end
      StDone: begin
        done_c  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (bus.flush) begin
      state_d = StIdle;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      stall_c = 1'b0;
      done_c  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // A start seen while reset is held must not hold the pipeline.
  assign bus.stall = stall_c & rst_n;
  assign bus.done  = done_c;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected HI/LO and stall length, a negedge
// monitor pops and compares on every done pulse.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int unsigned W = 32;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mdu_ctrl_if #(.DATA_W(W)) bus ();

  mdu_ctrl #(
    .DATA_W (W),
    .CNT_W  (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        sb_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int          stall_run = 0;
  logic [31:0] m_hi, m_lo;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Reference model: plain wide arithmetic on the architectural HI/LO.
  function automatic exp_t ref_op(input logic [5:0] f, input logic [31:0] a,
                                  input logic [31:0] b);
    exp_t        e;
    longint      sa, sb;
    logic [63:0] r;
    sa       = longint'($signed(a));
    sb       = longint'($signed(b));
    e.hi     = m_hi;
    e.lo     = m_lo;
    e.stalls = 34;
    e.name   = $sformatf("f%h a%h b%h", f, a, b);
    case (f)
      FUNCT_MULT: begin
        r = sa * sb;
        e.hi = r[63:32];
        e.lo = r[31:0];
      end
      FUNCT_MULTU: begin
        r = {32'b0, a} * {32'b0, b};
        e.hi = r[63:32];
        e.lo = r[31:0];
      end
      FUNCT_DIV: begin
        if (b == 32'b0) e.stalls = 1;
        else begin
          r = sa / sb;
          e.lo = r[31:0];
          r = sa % sb;
          e.hi = r[31:0];
        end
      end
      FUNCT_DIVU: begin
        if (b == 32'b0) e.stalls = 1;
        else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n !== 1'b1) begin
      stall_run = 0;
    end else if (bus.stall === 1'b1) begin
      stall_run++;
    end else begin
      if (bus.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got done=1 with empty scoreboard, required done=0");
        end else begin
          e = sb_q.pop_front();
          check32({e.name, " hi"}, bus.hi, e.hi);
          check32({e.name, " lo"}, bus.lo, e.lo);
          check_int({e.name, " stall_cycles"}, stall_run, e.stalls);
        end
      end
      stall_run = 0;
    end
  end

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_done);
    exp_t e;
    e = ref_op(f, a, b);
    if (expect_done) begin
      sb_q.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
    end
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.funct = f;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Operands are scrambled while busy; they must have been sampled at accept only.
  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
      else begin
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
        bus.funct = 6'($urandom);
      end
    end
    if (!seen) begin
      n_total++;
      $display("FAIL %s timeout: got no done in 60 cycles, required a done pulse", name);
    end
    @(posedge clk);
  endtask

  task automatic mt(input logic [5:0] f, input logic [31:0] v);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.funct = f;
    bus.op_a  = v;
    @(negedge clk);
    check_int("mt stall", int'(bus.stall), 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (f == FUNCT_MTHI) m_hi = v;
    else m_lo = v;
    check32("mt hi", bus.hi, m_hi);
    check32("mt lo", bus.lo, m_lo);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us, required finish");
    $fatal(1);
  end

  initial begin
    logic [5:0]  fl [6];
    logic [5:0]  f;
    logic [31:0] a, b;
    int          dones;

    fl = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO};
    rst_n     = 1'b0;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    bus.funct = '0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    m_hi      = '0;
    m_lo      = '0;

    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.funct = FUNCT_MULT;
    #1;
    check32("reset hi", bus.hi, 32'h0);
    check32("reset lo", bus.lo, 32'h0);
    check_int("reset stall", int'(bus.stall), 0);
    check_int("reset done", int'(bus.done), 0);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    issue(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done("multu max");
    issue(FUNCT_MULT,  32'hFFFF_FFFD, 32'd7, 1'b1);         wait_done("mult -3*7");
    issue(FUNCT_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1);         wait_done("div -7/2");
    issue(FUNCT_DIVU,  32'd100, 32'd7, 1'b1);               wait_done("divu 100/7");
    mt(FUNCT_MTHI, 32'h1234);
    mt(FUNCT_MTLO, 32'h5678);
    issue(FUNCT_DIV, 32'd5, 32'd0, 1'b1);                   wait_done("div by zero");
    issue(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);   wait_done("div overflow");

    // Flush on CALC cycle 10 aborts without committing or pulsing done.
    issue(FUNCT_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    #1;
    check_int("flush stall", int'(bus.stall), 0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check_int("post-flush stall", int'(bus.stall), 0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check_int("flush no done", dones, 0);
    check32("flush hi", bus.hi, m_hi);
    check32("flush lo", bus.lo, m_lo);

    @(posedge clk); #1;
    bus.flush = 1'b1;
    bus.start = 1'b1;
    bus.funct = FUNCT_MTHI;
    bus.op_a  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    check32("flushed mthi", bus.hi, m_hi);

    issue(FUNCT_MULTU, 32'd3, 32'd5, 1'b1); wait_done("multu 3*5");

    for (int i = 0; i < 24; i++) begin
      f = fl[$urandom_range(0, 5)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'h0;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 31);
      if (f == FUNCT_MTHI || f == FUNCT_MTLO) mt(f, a);
      else begin
        issue(f, a, b, 1'b1);
        wait_done("random op");
      end
    end

    // Reset during FIX: HI/LO clear at once and stall drops.
    issue(FUNCT_MULTU, $urandom, $urandom, 1'b0);
    repeat (32) @(posedge clk);
    #1;
    check_int("fix stall", int'(bus.stall), 1);
    rst_n = 1'b0;
    #1;
    check32("rst-in-fix hi", bus.hi, 32'h0);
    check32("rst-in-fix lo", bus.lo, 32'h0);
    check_int("rst-in-fix stall", int'(bus.stall), 0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mt(FUNCT_MTLO, 32'hA5A5_A5A5);

    repeat (3) @(posedge clk);
    check_int("scoreboard drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
